seq_shift_multiplier: RTL and testbench
=======================================

SEQ_SHIFT_MULTIPLIER -- requirements
Module: seq_shift_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (legal range 2..32).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request to begin a multiply; sampled on clk rising edge.
REQ-005 SHALL have port multiplicand  input  WIDTH  first operand; sampled only with an accepted start.
REQ-006 SHALL have port multiplier  input  WIDTH  second operand; sampled only with an accepted start.
REQ-007 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-008 SHALL have port done  output  1  one-cycle pulse marking a valid new product.
REQ-009 SHALL have port product  output  2*WIDTH  registered result; holds until the next completion.

Function
REQ-010 SHALL implement the FSM states IDLE, CALC and DONE.
REQ-011 SHALL take the IDLE->CALC transition on an edge with start=1; that edge latches both operands, clears the accumulator and clears the bit counter.
REQ-012 SHALL, on each CALC edge, add the shifted multiplicand into the 2*WIDTH accumulator when multiplier_reg[0]=1, left-shift the multiplicand register by 1, right-shift multiplier_reg by 1 and increment the counter.
REQ-013 SHALL transition CALC->DONE on the WIDTH-th CALC edge and load product from the accumulator on that edge.
REQ-014 SHALL have done=1 only in DONE (exactly one cycle), with DONE->IDLE unconditional.
REQ-015 SHALL have latency from the start-accepting edge to done high equal to WIDTH edges, giving a new start accepted at most every WIDTH+2 cycles.
REQ-016 SHALL ignore start in CALC or DONE; the in-flight operands are unaffected.
REQ-017 SHALL leave operand input changes after acceptance without effect on the result.
REQ-018 SHALL keep all arithmetic modulo 2^(2*WIDTH) with no overflow possible, so the unsigned result is exact.
REQ-019 SHALL keep product stable outside the DONE-entry edge, including while a new operation runs.

Reset
REQ-020 SHALL, while rst_n=0, immediately force state IDLE, busy=0, done=0, product=0, and clear the accumulator, counter and operand registers, independent of clk.
REQ-021 SHALL, on reset asserted mid-CALC, discard the in-flight result, with no done pulse after release.
REQ-022 SHALL accept start on the first rising edge after rst_n deasserts.

Configuration
REQ-023 SHALL, when macro SIGNED_MODE_EN is defined, add input port is_signed (1 bit, sampled with start); is_signed=1 treats operands as two's complement (magnitudes multiplied, product negated when the operand signs differ, applied on the DONE-entry edge), and is_signed=0 behaves unsigned.
REQ-024 SHALL, when SIGNED_MODE_EN is undefined, omit port is_signed and operate unsigned only, with latency identical in both builds.

Structure
REQ-025 SHALL place the state enum typedef (IDLE/CALC/DONE) and the default-width constant in package seq_mult_pkg.
REQ-026 SHALL place the FSM and bit counter in sub-module seq_mult_ctrl, with the datapath (operand regs, accumulator, sign fix-up) in the top.

Verification
REQ-027 SHALL cover reset: rst_n=0 at t=0 -> product=0, busy=0, done=0; release, start with 3*4 -> product=12.
REQ-028 SHALL cover a max-value operation: WIDTH=16, 0xFFFF*0xFFFF -> product=0xFFFE0001, done high for exactly 1 cycle, 16 edges after the start edge, busy high 17 cycles.
REQ-029 SHALL cover zero and identity: 0*0x1234 -> 0; 0x0001*0xABCD -> 0x0000ABCD.
REQ-030 SHALL cover start while busy: start 7*9, re-pulse start with 100*100 at CALC edge 5 -> single done, product=63.
REQ-031 SHALL cover reset mid-operation: rst_n=0 at CALC edge 8 of 0x1234*0x5678 -> no done, product=0; a fresh start gives 0x06260060.
REQ-032 SHALL cover signed mode (SIGNED_MODE_EN, is_signed=1): 0xFFFD*0x0005 -> 0xFFFFFFF1; 0x8000*0x8000 -> 0x40000000; plus 10 random pairs matching the reference multiply.

Source files
------------

// File: rtl/seq_mult_pkg.sv
// Shared types and constants for the sequential shift-and-add multiplier.
package seq_mult_pkg;

    localparam int DEF_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_shift_multiplier_if.sv
// Request/result bundle for seq_shift_multiplier; is_signed exists only when
// SIGNED_MODE_EN is defined.
interface seq_shift_multiplier_if #(
    parameter int WIDTH = seq_mult_pkg::DEF_WIDTH
);
    logic                 start;
    logic [WIDTH-1:0]     multiplicand;
    logic [WIDTH-1:0]     multiplier;
`ifdef SIGNED_MODE_EN
    logic                 is_signed;
`endif
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

`ifdef SIGNED_MODE_EN
    modport master (output start, multiplicand, multiplier, is_signed,
                    input  busy, done, product);
    modport slave  (input  start, multiplicand, multiplier, is_signed,
                    output busy, done, product);
`else
    modport master (output start, multiplicand, multiplier,
                    input  busy, done, product);
    modport slave  (input  start, multiplicand, multiplier,
                    output busy, done, product);
`endif
endinterface

// File: rtl/seq_mult_ctrl.sv
// IDLE/CALC/DONE sequencer and bit counter; tells the datapath when to load,
// step and capture the product.
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic load,
    output logic calc,
    output logic last,
    output logic busy,
    output logic done
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          cnt_end;

    assign cnt_end = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    cnt <= '0;
        else if (load) cnt <= '0;
        else if (calc) cnt <= cnt + 1'b1;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)   state_nxt = CALC;
            CALC:    if (cnt_end) state_nxt = DONE;
            DONE:                 state_nxt = IDLE;
            default:              state_nxt = IDLE;
        endcase
    end

    always_comb begin
        load = (state == IDLE) && start;
        calc = (state == CALC);
        last = (state == CALC) && cnt_end;
        busy = (state != IDLE);
        done = (state == DONE);
    end

endmodule

// File: rtl/seq_shift_multiplier.sv
// Shift-and-add multiplier, one multiplier bit per cycle. Define SIGNED_MODE_EN
// for two's-complement support via bus.is_signed (sign-magnitude fix-up).
module seq_shift_multiplier
    import seq_mult_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_shift_multiplier_if.slave   bus
);
    localparam int PW = 2 * WIDTH;

    logic             load, calc, last, busy, done;
    logic [PW-1:0]    mcand_q, acc_q, product_q, sum, result;
    logic [WIDTH-1:0] mplier_q, a_in, b_in;

    seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .start (bus.start),
        .load  (load),
        .calc  (calc),
        .last  (last),
        .busy  (busy),
        .done  (done)
    );

    assign sum = acc_q + (mplier_q[0] ? mcand_q : '0);

`ifdef SIGNED_MODE_EN
    // Magnitudes go through the unsigned core; the sign is restored at capture.
    logic neg_q;
    assign a_in = (bus.is_signed && bus.multiplicand[WIDTH-1]) ? -bus.multiplicand : bus.multiplicand;
    assign b_in = (bus.is_signed && bus.multiplier[WIDTH-1])   ? -bus.multiplier   : bus.multiplier;
    assign result = neg_q ? -sum : sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    neg_q <= 1'b0;
        else if (load) neg_q <= bus.is_signed & (bus.multiplicand[WIDTH-1] ^ bus.multiplier[WIDTH-1]);
    end
`else
    assign a_in   = bus.multiplicand;
    assign b_in   = bus.multiplier;
    assign result = sum;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            product_q <= '0;
        end else begin
            if (load) begin
                mcand_q  <= PW'(a_in);
                mplier_q <= b_in;
                acc_q    <= '0;
            end else if (calc) begin
                acc_q    <= sum;
                mcand_q  <= mcand_q << 1;
                mplier_q <= mplier_q >> 1;
            end
            if (last) product_q <= result;
        end
    end

    assign bus.busy    = busy;
    assign bus.done    = done;
    assign bus.product = product_q;

endmodule

// File: tb/tb_seq_shift_multiplier.sv
// Randomized self-checking bench for seq_shift_multiplier against a plain
// arithmetic reference multiply.
module tb_seq_shift_multiplier;
    import seq_mult_pkg::*;

    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    seq_shift_multiplier_if #(.WIDTH(W)) bus ();

    seq_shift_multiplier #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        logic signed [W-1:0] sa, sb;
        logic [63:0]         r;
        sa = a;
        sb = b;
        if (sgn) r = 64'(longint'(sa) * longint'(sb));
        else     r = 64'(a) * 64'(b);
        return r & ((64'd1 << (2 * W)) - 64'd1);
    endfunction

    task automatic set_ops(input logic [W-1:0] a, input logic [W-1:0] b, input bit sgn);
        bus.multiplicand = a;
        bus.multiplier   = b;
`ifdef SIGNED_MODE_EN
        bus.is_signed    = sgn;
`else
        if (sgn) $display("note: signed request ignored in unsigned build");
`endif
    endtask

    // Starts an operation on the next rising edge; caller is at a negedge.
    task automatic mul_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit sgn, input int repulse_at, input int reset_at);
        logic [63:0] exp, prev;
        int dcnt, bcnt, lat;
        dcnt = 0; bcnt = 0; lat = -1;
        exp  = ref_mul(a, b, sgn);
        prev = bus.product;
        set_ops(a, b, sgn);
        bus.start = 1'b1;
        @(posedge clk);
        for (int k = 0; k < W + 4; k++) begin
            @(negedge clk);
            if (k == 0) begin
                bus.start = 1'b0;
                set_ops(W'($urandom), W'($urandom), ~sgn);
            end
            if (k == repulse_at) begin
                bus.start = 1'b1;
                set_ops(W'(100), W'(100), 1'b0);
            end
            if (k == repulse_at + 1) bus.start = 1'b0;
            if (reset_at >= 0 && k == reset_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, ":rst_busy"}, 64'(bus.busy), 64'd0);
                chk({tag, ":rst_done"}, 64'(bus.done), 64'd0);
                chk({tag, ":rst_prod"}, 64'(bus.product), 64'd0);
            end
            if (reset_at >= 0 && k == reset_at + 2) rst_n = 1'b1;
            if (bus.busy) bcnt++;
            if (bus.done) begin
                dcnt++;
                if (lat < 0) lat = k;
            end
            if (k == 3) chk({tag, ":hold"}, 64'(bus.product), prev);
        end
        if (reset_at >= 0) begin
            chk({tag, ":no_done"}, 64'(dcnt), 64'd0);
            chk({tag, ":prod_clr"}, 64'(bus.product), 64'd0);
        end else begin
            chk({tag, ":done_cnt"}, 64'(dcnt), 64'd1);
            chk({tag, ":latency"}, 64'(lat), 64'(W));
            chk({tag, ":busy_cyc"}, 64'(bcnt), 64'(W + 1));
            chk({tag, ":product"}, 64'(bus.product), exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.start = 1'b0;
        set_ops('0, '0, 1'b0);
        #1;
        chk("reset:prod", 64'(bus.product), 64'd0);
        chk("reset:busy", 64'(bus.busy), 64'd0);
        chk("reset:done", 64'(bus.done), 64'd0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        mul_op("3x4",       W'(3),      W'(4),      1'b0, -1, -1);
        mul_op("max",       W'(16'hFFFF), W'(16'hFFFF), 1'b0, -1, -1);
        mul_op("zero",      W'(0),      W'(16'h1234), 1'b0, -1, -1);
        mul_op("ident",     W'(1),      W'(16'hABCD), 1'b0, -1, -1);
        mul_op("busy_start", W'(7),     W'(9),      1'b0, 4, -1);
        mul_op("mid_reset", W'(16'h1234), W'(16'h5678), 1'b0, -1, 7);
        mul_op("fresh",     W'(16'h1234), W'(16'h5678), 1'b0, -1, -1);

        for (int i = 0; i < 20; i++)
            mul_op($sformatf("rnd%0d", i), W'($urandom), W'($urandom), 1'b0, -1, -1);

`ifdef SIGNED_MODE_EN
        mul_op("s_neg3x5",  W'(16'hFFFD), W'(16'h0005), 1'b1, -1, -1);
        mul_op("s_min_sq",  W'(16'h8000), W'(16'h8000), 1'b1, -1, -1);
        mul_op("u_fffdx5",  W'(16'hFFFD), W'(16'h0005), 1'b0, -1, -1);
        for (int i = 0; i < 10; i++)
            mul_op($sformatf("srnd%0d", i), W'($urandom), W'($urandom), 1'b1, -1, -1);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
